pkg_frame: RTL and testbench

Framing stage directly downstream of the package path. It captures one complete package from the `pkg_d`/`pkg_vld` stream into an internal buffer. It then emits the package as a framed transmit stream: sync word, ID/sequence header, payload and optional checksum, with ready/valid backpressure toward the host-side (FX) transmit logic. `pkg_done` is returned upstream to release the next package.

---
 rtl/pkg_frame.sv | 107 ++++++++++
 tb/tb_pkg_frame.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/pkg_frame.sv
// pkg_frame: buffers one package, then sends it as sync + header + payload (+ checksum) with ready/valid.
// Ports: clk_sys/rst_n (async active-low) clock and reset; dev_id header device ID;
//        pkg_d/pkg_vld package input stream (no backpressure); pkg_done one-cycle release pulse;
//        tx_d/tx_vld/tx_rdy framed transmit stream; frm_busy high outside RECV; frm_ovf sticky drop flag.
// Build option: define PKG_FRAME_CSUM_EN to append the checksum word (frame = PKG_WORDS+3 words).
module pkg_frame #(
  parameter int          PKG_WORDS = 256,
  parameter logic [15:0] SYNC_WORD = 16'h55AA
) (
  input  logic        clk_sys,
  input  logic        rst_n,
  input  logic [5:0]  dev_id,
  input  logic [15:0] pkg_d,
  input  logic        pkg_vld,
  output logic        pkg_done,
  output logic [15:0] tx_d,
  output logic        tx_vld,
  input  logic        tx_rdy,
  output logic        frm_busy,
  output logic        frm_ovf
);
  localparam int AW = PKG_WORDS > 1 ? $clog2(PKG_WORDS) : 1;
  localparam logic [AW-1:0] LAST = AW'(PKG_WORDS - 1);
  typedef enum logic [2:0] {
    RECV, SYNC, HEAD, DATA,
`ifdef PKG_FRAME_CSUM_EN
    CSUM,
`endif
    DONE
  } state_t;
  state_t state_q, state_d;
  logic [AW-1:0] wcnt_q, wcnt_d, rcnt_q, rcnt_d, raddr;
  logic [7:0] seq_q, seq_d;
  logic [15:0] tx_d_q, tx_d_d, rd_q, hdr, tail;
  logic tx_vld_q, tx_vld_d, ovf_q, ovf_d, acc, wr;
  logic [15:0] mem [PKG_WORDS];
  assign hdr = {2'b00, dev_id, seq_q};
  assign acc = tx_vld_q && tx_rdy;
  assign wr  = state_q == RECV && pkg_vld;
`ifdef PKG_FRAME_CSUM_EN
  logic [15:0] csum_q, csum_d;
  assign csum_d = state_q == DONE ? 16'h0 : wr ? csum_q + pkg_d : csum_q;
  assign tail   = csum_q + hdr;
  always_ff @(posedge clk_sys or negedge rst_n)
    if (!rst_n) csum_q <= '0;
    else csum_q <= csum_d;
`else
  assign tail = tx_d_q;
`endif
  always_ff @(posedge clk_sys or negedge rst_n)
    if (!rst_n) state_q <= RECV;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      RECV: if (wr && wcnt_q == LAST) state_d = SYNC;
      SYNC: if (acc) state_d = HEAD;
      HEAD: if (acc) state_d = DATA;
`ifdef PKG_FRAME_CSUM_EN
      DATA: if (acc && rcnt_q == LAST) state_d = CSUM;
      CSUM: if (acc) state_d = DONE;
`else
      DATA: if (acc && rcnt_q == LAST) state_d = DONE;
`endif
      default: state_d = RECV;
    endcase
  end
  // Read address follows the next-state index so rd_q always holds the word to load on the next
  // acceptance; outside DATA it parks on word 0, which is the prefetch needed when HEAD is accepted.
  always_comb begin
    wcnt_d   = wr ? (wcnt_q == LAST ? '0 : wcnt_q + 1'b1) : wcnt_q;
    rcnt_d   = state_q == DATA && acc ? (rcnt_q == LAST ? '0 : rcnt_q + 1'b1) : rcnt_q;
    raddr    = state_d == DATA && rcnt_d != LAST ? rcnt_d + 1'b1 : '0;
    seq_d    = state_q == DONE ? seq_q + 8'd1 : seq_q;
    ovf_d    = ovf_q | (pkg_vld && state_q != RECV);
    tx_vld_d = state_q != RECV && state_q != DONE && state_d != DONE;
    tx_d_d   = state_q == SYNC && !tx_vld_q ? SYNC_WORD :
               !acc                          ? tx_d_q    :
               state_d == HEAD               ? hdr       :
               state_d == DATA               ? rd_q      : tail;
  end
  always_ff @(posedge clk_sys or negedge rst_n)
    if (!rst_n) begin
      wcnt_q   <= '0;
      rcnt_q   <= '0;
      seq_q    <= '0;
      ovf_q    <= 1'b0;
      tx_vld_q <= 1'b0;
      tx_d_q   <= '0;
    end else begin
      wcnt_q   <= wcnt_d;
      rcnt_q   <= rcnt_d;
      seq_q    <= seq_d;
      ovf_q    <= ovf_d;
      tx_vld_q <= tx_vld_d;
      tx_d_q   <= tx_d_d;
    end
  always_ff @(posedge clk_sys) begin
    if (wr) mem[wcnt_q] <= pkg_d;
    rd_q <= mem[raddr];
  end
  assign tx_d     = tx_d_q;
  assign tx_vld   = tx_vld_q;
  assign pkg_done = state_q == DONE;
  assign frm_busy = state_q != RECV;
  assign frm_ovf  = ovf_q;
endmodule

// File: tb/tb_pkg_frame.sv
// tb_pkg_frame: randomized self-checking bench for pkg_frame against a frame-level queue model.
module tb_pkg_frame;
  localparam int P = 4;
`ifdef PKG_FRAME_CSUM_EN
  localparam int FL = P + 3;
`else
  localparam int FL = P + 2;
`endif
  logic clk_sys = 0, rst_n = 0, pkg_vld = 0, tx_rdy = 0;
  logic [5:0] dev_id = 6'h2A;
  logic [15:0] pkg_d = 0, tx_d, hold_d;
  logic pkg_done, tx_vld, frm_busy, frm_ovf;
  int checks = 0, errors = 0, cyc = 0, first_cyc = 0, last_cyc = 0, mode = 0, seq_m = 0;
  bit stall = 0;
  logic [15:0] got_q[$];
  logic [15:0] d [P];
  pkg_frame #(.PKG_WORDS(P), .SYNC_WORD(16'h55AA)) dut (
    .clk_sys(clk_sys), .rst_n(rst_n), .dev_id(dev_id), .pkg_d(pkg_d), .pkg_vld(pkg_vld),
    .pkg_done(pkg_done), .tx_d(tx_d), .tx_vld(tx_vld), .tx_rdy(tx_rdy),
    .frm_busy(frm_busy), .frm_ovf(frm_ovf));
  always #5 clk_sys = ~clk_sys;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  initial forever begin
    @(posedge clk_sys);
    #1;
    tx_rdy = mode == 0 ? 1'b1 : mode == 1 ? ~tx_rdy : 1'($urandom_range(0, 1));
  end
  always @(negedge clk_sys) begin
    cyc++;
    if (!rst_n) stall = 0;
    else begin
      if (stall) begin
        chk("hold_vld", {31'b0, tx_vld}, 1);
        chk("hold_d", {16'b0, tx_d}, {16'b0, hold_d});
      end
      stall = tx_vld && !tx_rdy;
      hold_d = tx_d;
      if (tx_vld && tx_rdy) begin
        if (got_q.size() == 0) first_cyc = cyc;
        got_q.push_back(tx_d);
        last_cyc = cyc;
      end
      if (pkg_done) begin
        chk("done_vld", {31'b0, tx_vld}, 0);
        chk("done_lat", cyc - last_cyc, 1);
      end
    end
  end
  task automatic rand_d();
    for (int i = 0; i < P; i++) d[i] = 16'($urandom);
  endtask
  task automatic send_words();
    for (int i = 0; i < P; i++) begin
      @(posedge clk_sys);
      #1;
      pkg_vld = 1;
      pkg_d = d[i];
    end
  endtask
  task automatic run_pkg(input bit ovf, input string tag);
    logic [15:0] exp_q[$];
    logic [15:0] s, hdr;
    bit done, inj;
    done = 0;
    inj = 0;
    hdr = {2'b00, dev_id, 8'(seq_m)};
    s = hdr;
    exp_q.push_back(16'h55AA);
    exp_q.push_back(hdr);
    for (int i = 0; i < P; i++) begin
      exp_q.push_back(d[i]);
      s = s + d[i];
    end
`ifdef PKG_FRAME_CSUM_EN
    exp_q.push_back(s);
`endif
    got_q.delete();
    send_words();
    for (int c = 0; c < 200 && !done; c++) begin
      @(posedge clk_sys);
      #1;
      pkg_vld = ovf && !inj && got_q.size() == 3;
      if (pkg_vld) begin
        pkg_d = 16'($urandom);
        inj = 1;
      end
      @(negedge clk_sys);
      done = pkg_done;
    end
    chk({tag, "_done"}, {31'b0, done}, 1);
    chk({tag, "_len"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      chk($sformatf("%s_w%0d", tag, i), got_q.size() > i ? {16'b0, got_q[i]} : 32'hDEAD0000, {16'b0, exp_q[i]});
    if (mode == 0) chk({tag, "_contig"}, last_cyc - first_cyc + 1, FL);
    seq_m = (seq_m + 1) % 256;
  endtask
  initial begin
    repeat (2) @(posedge clk_sys);
    #1;
    chk("rst_vld", {31'b0, tx_vld}, 0);
    chk("rst_d", {16'b0, tx_d}, 0);
    chk("rst_done", {31'b0, pkg_done}, 0);
    chk("rst_busy", {31'b0, frm_busy}, 0);
    chk("rst_ovf", {31'b0, frm_ovf}, 0);
    rst_n = 1;
    d = '{16'd1, 16'd2, 16'd3, 16'd4};
    mode = 0;
    run_pkg(0, "s1");
    mode = 1;
    run_pkg(0, "s2");
    chk("ovf_clear", {31'b0, frm_ovf}, 0);
    mode = 2;
    rand_d();
    run_pkg(1, "ovf");
    chk("ovf_set", {31'b0, frm_ovf}, 1);
    mode = 0;
    rand_d();
    got_q.delete();
    send_words();
    @(posedge clk_sys);
    #1;
    pkg_vld = 0;
    for (int c = 0; c < 50 && got_q.size() < 3; c++) @(negedge clk_sys);
    chk("mid_reach", {31'b0, got_q.size() >= 3}, 1);
    #2;
    rst_n = 0;
    #1;
    chk("mid_vld", {31'b0, tx_vld}, 0);
    chk("mid_d", {16'b0, tx_d}, 0);
    chk("mid_busy", {31'b0, frm_busy}, 0);
    chk("mid_ovf", {31'b0, frm_ovf}, 0);
    seq_m = 0;
    repeat (2) @(posedge clk_sys);
    #1;
    rst_n = 1;
    rand_d();
    run_pkg(0, "rst");
    for (int n = 0; n < 257; n++) begin
      mode = $urandom_range(0, 2);
      rand_d();
      run_pkg(0, "bb");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
